// File: rtl/input_stream_scheduler.sv
// Strided read sequencer for the fabric input nodes: issues per-channel address streams
// round-robin onto one memory read port and steers in-order responses into per-channel stream buffers.
module input_stream_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int MAX_OUT   = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_CH*32-1:0] cfg_addr_i,
    input  logic [NUM_CH*16-1:0] cfg_size_i,
    input  logic [NUM_CH*16-1:0] cfg_stride_i,
    output logic                 mem_req_o,
    output logic [31:0]          mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic [NUM_CH-1:0]    ch_valid_o,
    output logic [NUM_CH*32-1:0] ch_data_o,
    input  logic [NUM_CH-1:0]    ch_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    // state   | meaning
    // S_IDLE  | waiting for start_i, configuration latched on start
    // S_RUN   | issuing reads and delivering stream data
    // S_DONE  | one-cycle completion pulse
    // S_FLUSH | abort: no issue, responses dropped until the tag FIFO drains

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TAG_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int TAG_CW = $clog2(MAX_OUT) + 1;
    localparam int BUF_PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;

    localparam logic [CNT_W:0]      CREDIT_LIM = (CNT_W+1)'(BUF_DEPTH);
    localparam logic [TAG_CW-1:0]   TAG_FULL   = TAG_CW'(MAX_OUT);
    localparam logic [CH_W-1:0]     CH_LAST    = CH_W'(NUM_CH - 1);
    localparam logic [TAG_PW-1:0]   TAG_LAST   = TAG_PW'(MAX_OUT - 1);
    localparam logic [BUF_PW-1:0]   BUF_LAST   = BUF_PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       next_addr_q [NUM_CH];
    logic [15:0]       remaining_q [NUM_CH];
    logic [15:0]       stride_q    [NUM_CH];
    logic [CNT_W-1:0]  inflight_q  [NUM_CH];
    logic [CNT_W-1:0]  occ_q       [NUM_CH];
    logic [BUF_PW-1:0] buf_wp_q    [NUM_CH];
    logic [BUF_PW-1:0] buf_rp_q    [NUM_CH];
    logic [31:0]       buf_mem_q   [NUM_CH][BUF_DEPTH];

    logic [CH_W-1:0]   tag_mem_q [MAX_OUT];
    logic [TAG_PW-1:0] tag_wp_q, tag_rp_q;
    logic [TAG_CW-1:0] tag_cnt_q;

    logic [CH_W-1:0]   rr_ptr_q, hold_ch_q, sel_ch, rsp_ch;
    logic              hold_q, found, issue, grant, rsp, flush_bufs;
    logic              all_rem_zero, bufs_empty;
    logic [NUM_CH-1:0] elig, gnt_vec, rsp_vec, wr_vec, pop_vec;

    // Credit rule: a channel may only have as many reads in flight as it has free buffer slots.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = (remaining_q[c] != '0) &&
                      (({1'b0, occ_q[c]} + {1'b0, inflight_q[c]}) < CREDIT_LIM);
        end
    end

    // A stalled request keeps its channel until granted, even if another channel becomes eligible.
    always_comb begin
        int idx;
        idx    = 0;
        sel_ch = rr_ptr_q;
        found  = 1'b0;
        if (hold_q) begin
            sel_ch = hold_ch_q;
            found  = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && elig[idx]) begin
                    sel_ch = CH_W'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    assign issue      = (state_q == S_RUN) && (tag_cnt_q != TAG_FULL) && found;
    assign mem_req_o  = issue;
    assign mem_addr_o = issue ? next_addr_q[sel_ch] : 32'd0;
    assign grant      = issue && mem_gnt_i;
    assign rsp        = mem_rvalid_i && (tag_cnt_q != '0);
    assign rsp_ch     = tag_mem_q[tag_rp_q];
    assign flush_bufs = ((state_q == S_RUN) && abort_i) || (state_q == S_FLUSH);

    always_comb begin
        all_rem_zero = 1'b1;
        bufs_empty   = 1'b1;
        gnt_vec      = '0;
        rsp_vec      = '0;
        wr_vec       = '0;
        pop_vec      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (remaining_q[c] != '0) all_rem_zero = 1'b0;
            if (occ_q[c] != '0)       bufs_empty   = 1'b0;
            gnt_vec[c] = grant && (sel_ch == CH_W'(c));
            rsp_vec[c] = rsp && (rsp_ch == CH_W'(c));
            wr_vec[c]  = rsp_vec[c] && (state_q == S_RUN);
            pop_vec[c] = (occ_q[c] != '0) && ch_ready_i[c];
        end
    end

    always_comb begin
        ch_valid_o = '0;
        ch_data_o  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_valid_o[c] = (occ_q[c] != '0);
            if (occ_q[c] != '0) ch_data_o[c*32 +: 32] = buf_mem_q[c][buf_rp_q[c]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (abort_i)                                             state_d = S_FLUSH;
                else if (all_rem_zero && (tag_cnt_q == '0) && bufs_empty) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                busy_o = 1'b1;
                if (tag_cnt_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            hold_q    <= 1'b0;
            hold_ch_q <= '0;
        end else begin
            if (grant) rr_ptr_q <= (sel_ch == CH_LAST) ? '0 : sel_ch + 1'b1;
            hold_q    <= issue && !mem_gnt_i && !abort_i;
            hold_ch_q <= sel_ch;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_wp_q  <= '0;
            tag_rp_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (grant) tag_wp_q <= (tag_wp_q == TAG_LAST) ? '0 : tag_wp_q + 1'b1;
            if (rsp)   tag_rp_q <= (tag_rp_q == TAG_LAST) ? '0 : tag_rp_q + 1'b1;
            case ({grant, rsp})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) tag_mem_q[tag_wp_q] <= sel_ch;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_vec[c]) buf_mem_q[c][buf_wp_q[c]] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                next_addr_q[c] <= '0;
                remaining_q[c] <= '0;
                stride_q[c]    <= '0;
                inflight_q[c]  <= '0;
                occ_q[c]       <= '0;
                buf_wp_q[c]    <= '0;
                buf_rp_q[c]    <= '0;
            end
        end else if ((state_q == S_IDLE) && start_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                next_addr_q[c] <= cfg_addr_i[c*32 +: 32];
                remaining_q[c] <= cfg_size_i[c*16 +: 16];
                stride_q[c]    <= cfg_stride_i[c*16 +: 16];
                inflight_q[c]  <= '0;
                occ_q[c]       <= '0;
                buf_wp_q[c]    <= '0;
                buf_rp_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt_vec[c]) begin
                    next_addr_q[c] <= next_addr_q[c] + {16'd0, stride_q[c]};
                    remaining_q[c] <= remaining_q[c] - 16'd1;
                end else if (flush_bufs) begin
                    remaining_q[c] <= '0;
                end
                case ({gnt_vec[c], rsp_vec[c]})
                    2'b10:   inflight_q[c] <= inflight_q[c] + 1'b1;
                    2'b01:   inflight_q[c] <= inflight_q[c] - 1'b1;
                    default: inflight_q[c] <= inflight_q[c];
                endcase
                if (flush_bufs) begin
                    occ_q[c]    <= '0;
                    buf_wp_q[c] <= '0;
                    buf_rp_q[c] <= '0;
                end else begin
                    if (wr_vec[c])  buf_wp_q[c] <= (buf_wp_q[c] == BUF_LAST) ? '0 : buf_wp_q[c] + 1'b1;
                    if (pop_vec[c]) buf_rp_q[c] <= (buf_rp_q[c] == BUF_LAST) ? '0 : buf_rp_q[c] + 1'b1;
                    case ({wr_vec[c], pop_vec[c]})
                        2'b10:   occ_q[c] <= occ_q[c] + 1'b1;
                        2'b01:   occ_q[c] <= occ_q[c] - 1'b1;
                        default: occ_q[c] <= occ_q[c];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_input_stream_scheduler.sv
// Directed bench for input_stream_scheduler: in-order memory responder with optional response hold,
// grant/stream logging, and immediate-assertion checks against hand-derived expectations.
module tb_input_stream_scheduler;

    localparam logic [31:0] KEY = 32'h5A5A_5A5A;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [127:0] cfg_addr_i = '0;
    logic [63:0]  cfg_size_i = '0;
    logic [63:0]  cfg_stride_i = '0;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i = 1'b1;
    logic         mem_rvalid_i = 1'b0;
    logic [31:0]  mem_rdata_i = '0;
    logic [3:0]   ch_valid_o;
    logic [127:0] ch_data_o;
    logic [3:0]   ch_ready_i = 4'hF;
    logic         busy_o;
    logic         done_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] gl [256];
    int          gn;
    logic [31:0] rx_data [4][128];
    int          rx_n [4];
    int          done_cnt;
    int          rv_cnt;
    logic        resp_hold = 1'b0;
    logic [31:0] pend [$];

    input_stream_scheduler #(.NUM_CH(4), .MAX_OUT(4), .BUF_DEPTH(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_size_i  (cfg_size_i),
        .cfg_stride_i(cfg_stride_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .ch_valid_o  (ch_valid_o),
        .ch_data_o   (ch_data_o),
        .ch_ready_i  (ch_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge+1, then present the next in-order response at the following negedge.
    task automatic cycle();
        logic        g;
        logic [31:0] ga;
        #1;
        g  = mem_req_o && mem_gnt_i;
        ga = mem_addr_o;
        if (g) begin
            if (gn < 256) gl[gn] = ga;
            gn++;
            pend.push_back(ga);
        end
        for (int c = 0; c < 4; c++) begin
            if (ch_valid_o[c] && ch_ready_i[c]) begin
                if (rx_n[c] < 128) rx_data[c][rx_n[c]] = ch_data_o[c*32 +: 32];
                rx_n[c]++;
            end
        end
        if (done_o) done_cnt++;
        if (mem_rvalid_i) rv_cnt++;
        @(posedge clk);
        @(negedge clk);
        if (!resp_hold && pend.size() > 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend.pop_front() ^ KEY;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
    endtask

    task automatic clear_logs();
        gn = 0;
        done_cnt = 0;
        rv_cnt = 0;
        for (int c = 0; c < 4; c++) rx_n[c] = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        mem_gnt_i = 1'b1;
        resp_hold = 1'b0;
        ch_ready_i = 4'hF;
        cfg_addr_i = '0;
        cfg_size_i = '0;
        cfg_stride_i = '0;
        repeat (2) cycle();
        pend.delete();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        rst_ni = 1'b1;
        clear_logs();
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input logic [15:0] s, input logic [15:0] st);
        cfg_addr_i[c*32 +: 32]   = a;
        cfg_size_i[c*16 +: 16]   = s;
        cfg_stride_i[c*16 +: 16] = st;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_done_in_budget"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) cycle();
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_stream(input string tag, input int c, input logic [31:0] base,
                                input logic [31:0] stride, input int n);
        int errs;
        errs = 0;
        for (int k = 0; k < n && k < 128; k++) begin
            if (rx_data[c][k] !== ((base + 32'(k) * stride) ^ KEY)) errs++;
        end
        chk({tag, "_count"}, 32'(rx_n[c]), 32'(n));
        chk({tag, "_data_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int          errs;
        int          ch1_g;
        int          n;
        logic [31:0] bases [4];

        // Reset state
        clear_logs();
        rst_ni = 1'b0;
        repeat (2) cycle();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_valid", 32'(ch_valid_o), 32'd0);
        chk("rst_data_lo", ch_data_o[31:0], 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);

        // All channels disabled: done two cycles after start
        do_reset();
        pulse_start();
        chk("zero_busy_c1", 32'(busy_o), 32'd1);
        chk("zero_done_c1", 32'(done_o), 32'd0);
        chk("zero_req_c1", 32'(mem_req_o), 32'd0);
        cycle();
        chk("zero_done_c2", 32'(done_o), 32'd1);
        chk("zero_busy_c2", 32'(busy_o), 32'd0);
        cycle();
        chk("zero_done_c3", 32'(done_o), 32'd0);

        // Test 1: long single-channel stream
        do_reset();
        set_ch(0, 32'h8000_0000, 16'd80, 16'd4);
        pulse_start();
        chk("t1_req_latency", 32'(mem_req_o), 32'd1);
        chk("t1_first_addr", mem_addr_o, 32'h8000_0000);
        run_until_done("t1", 600);
        chk("t1_grants", 32'(gn), 32'd80);
        errs = 0;
        for (int i = 0; i < 80; i++) if (gl[i] !== 32'h8000_0000 + 32'(i) * 32'd4) errs++;
        chk("t1_addr_errs", 32'(errs), 32'd0);
        chk("t1_last_addr", gl[79], 32'h8000_013C);
        check_stream("t1_ch0", 0, 32'h8000_0000, 32'd4, 80);

        // Test 2: four channels round-robin
        do_reset();
        bases[0] = 32'h0000_1000;
        bases[1] = 32'h0000_2000;
        bases[2] = 32'h0000_3000;
        bases[3] = 32'h0000_4000;
        for (int c = 0; c < 4; c++) set_ch(c, bases[c], 16'd3, 16'd4);
        pulse_start();
        run_until_done("t2", 200);
        chk("t2_grants", 32'(gn), 32'd12);
        errs = 0;
        for (int i = 0; i < 12; i++) if (gl[i] !== bases[i % 4] + 32'(i / 4) * 32'd4) errs++;
        chk("t2_order_errs", 32'(errs), 32'd0);
        check_stream("t2_ch0", 0, bases[0], 32'd4, 3);
        check_stream("t2_ch1", 1, bases[1], 32'd4, 3);
        check_stream("t2_ch2", 2, bases[2], 32'd4, 3);
        check_stream("t2_ch3", 3, bases[3], 32'd4, 3);

        // Test 3: ch1 back-pressured
        do_reset();
        set_ch(0, 32'h0000_1000, 16'd10, 16'd4);
        set_ch(1, 32'h0000_2000, 16'd10, 16'd4);
        set_ch(2, 32'h0000_3000, 16'd10, 16'd4);
        ch_ready_i = 4'b1101;
        pulse_start();
        repeat (100) cycle();
        ch1_g = 0;
        for (int i = 0; i < gn && i < 256; i++) if (gl[i][31:12] == 20'h00002) ch1_g++;
        chk("t3_ch1_grants_held", 32'(ch1_g), 32'd2);
        chk("t3_ch0_done_words", 32'(rx_n[0]), 32'd10);
        chk("t3_ch2_done_words", 32'(rx_n[2]), 32'd10);
        chk("t3_ch1_valid", 32'(ch_valid_o[1]), 32'd1);
        chk("t3_busy_held", 32'(busy_o), 32'd1);
        ch_ready_i = 4'hF;
        run_until_done("t3", 200);
        check_stream("t3_ch0", 0, 32'h0000_1000, 32'd4, 10);
        check_stream("t3_ch1", 1, 32'h0000_2000, 32'd4, 10);
        check_stream("t3_ch2", 2, 32'h0000_3000, 32'd4, 10);

        // Test 4: grant stall holds the request
        do_reset();
        set_ch(0, 32'h0000_0100, 16'd4, 16'd4);
        set_ch(1, 32'h0000_0900, 16'd2, 16'd4);
        mem_gnt_i = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_req", 32'(mem_req_o), 32'd1);
            chk("t4_stall_addr", mem_addr_o, 32'h0000_0100);
            cycle();
        end
        chk("t4_no_grant_yet", 32'(gn), 32'd0);
        mem_gnt_i = 1'b1;
        run_until_done("t4", 100);
        chk("t4_grants", 32'(gn), 32'd6);
        chk("t4_g0", gl[0], 32'h0000_0100);
        chk("t4_g1", gl[1], 32'h0000_0900);
        chk("t4_g2", gl[2], 32'h0000_0104);
        chk("t4_g3", gl[3], 32'h0000_0904);
        chk("t4_g4", gl[4], 32'h0000_0108);
        chk("t4_g5", gl[5], 32'h0000_010C);

        // Test 5: address wrap and zero stride
        do_reset();
        set_ch(0, 32'hFFFF_FFF8, 16'd4, 16'd4);
        set_ch(1, 32'h0000_0040, 16'd2, 16'd0);
        pulse_start();
        run_until_done("t5", 100);
        chk("t5_grants", 32'(gn), 32'd6);
        chk("t5_g0", gl[0], 32'hFFFF_FFF8);
        chk("t5_g1", gl[1], 32'h0000_0040);
        chk("t5_g2", gl[2], 32'hFFFF_FFFC);
        chk("t5_g3", gl[3], 32'h0000_0040);
        chk("t5_g4", gl[4], 32'h0000_0000);
        chk("t5_g5", gl[5], 32'h0000_0004);
        check_stream("t5_ch0", 0, 32'hFFFF_FFF8, 32'd4, 4);
        check_stream("t5_ch1", 1, 32'h0000_0040, 32'd0, 2);

        // Test 6: abort with three reads outstanding, then a clean run
        do_reset();
        set_ch(0, 32'h0000_1000, 16'd8, 16'd4);
        set_ch(1, 32'h0000_2000, 16'd8, 16'd4);
        set_ch(2, 32'h0000_3000, 16'd8, 16'd4);
        resp_hold = 1'b1;
        pulse_start();
        repeat (3) cycle();
        chk("t6_outstanding", 32'(gn), 32'd3);
        mem_gnt_i = 1'b0;
        abort_i = 1'b1;
        chk("t6_req_at_abort", 32'(mem_req_o), 32'd1);
        cycle();
        abort_i = 1'b0;
        mem_gnt_i = 1'b1;
        chk("t6_req_after_abort", 32'(mem_req_o), 32'd0);
        chk("t6_busy_flush", 32'(busy_o), 32'd1);
        repeat (2) cycle();
        chk("t6_busy_waiting", 32'(busy_o), 32'd1);
        resp_hold = 1'b0;
        errs = 0;
        n = 0;
        while (busy_o && n < 10) begin
            if (ch_valid_o !== 4'h0) errs++;
            if (mem_req_o !== 1'b0) errs++;
            cycle();
            n++;
        end
        chk("t6_busy_fell", 32'(busy_o), 32'd0);
        chk("t6_flush_errs", 32'(errs), 32'd0);
        chk("t6_drained_rvalid", 32'(rv_cnt), 32'd3);
        chk("t6_pend_empty", 32'(pend.size()), 32'd0);
        chk("t6_no_new_grants", 32'(gn), 32'd3);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_no_stream", 32'(rx_n[0] + rx_n[1] + rx_n[2] + rx_n[3]), 32'd0);
        set_ch(0, 32'h0000_0700, 16'd2, 16'd4);
        set_ch(1, 32'h0, 16'd0, 16'd0);
        set_ch(2, 32'h0, 16'd0, 16'd0);
        clear_logs();
        pulse_start();
        run_until_done("t6b", 100);
        chk("t6b_grants", 32'(gn), 32'd2);
        chk("t6b_g0", gl[0], 32'h0000_0700);
        chk("t6b_g1", gl[1], 32'h0000_0704);
        check_stream("t6b_ch0", 0, 32'h0000_0700, 32'd4, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_stream_scheduler.md
Name: input_stream_scheduler

Overview:
- Sequences strided memory reads for all input nodes from the per-node addr/size/stride configuration and the execute-input pulse.
- Arbitrates the nodes round-robin onto one shared memory read port.
- Routes the returned words to per-node valid/ready streams feeding the fabric.
- Reports busy and done back to the control/status register block.

Parameters:
NUM_CH, 4, number of input nodes/channels
MAX_OUT, 4, max outstanding memory reads (power of 2)
BUF_DEPTH, 2, per-channel output buffer entries (power of 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  one-cycle start pulse (execute input)
abort_i  in  1  one-cycle flush pulse (reset state machines)
cfg_addr_i  in  32 x NUM_CH  base byte address per channel
cfg_size_i  in  16 x NUM_CH  word count per channel; 0 = channel disabled
cfg_stride_i  in  16 x NUM_CH  byte stride per channel, unsigned
mem_req_o  out  1  read request
mem_addr_o  out  32  read byte address
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid; in-order responses
mem_rdata_i  in  32  read data
ch_valid_o  out  NUM_CH  stream valid per channel
ch_data_o  out  32 x NUM_CH  stream data per channel
ch_ready_i  in  NUM_CH  stream ready per channel
busy_o  out  1  high from start accept until done/abort completes
done_o  out  1  one-cycle pulse on completion

Behaviour:
Reset values:
- All outputs are 0.
- FSM is in IDLE.
- Counters, tag FIFO and buffers are empty.
- RR pointer is 0.
- Reset mid-operation discards everything. The memory side is reset on the same reset.

FSM:
- IDLE: on start_i, latch cfg_* and set remaining[c] = size[c] and next_addr[c] = addr[c]. Go to RUN and assert busy_o next cycle.
- RUN: issue requests. Go to DONE when remaining all 0, tag FIFO empty and all buffers empty.
- DONE: pulse done_o for one cycle, deassert busy_o, go to IDLE.
- FLUSH: entered on abort_i from RUN. Stop issuing. Drop mem_rvalid_i data while the tag FIFO drains. Clear buffers. Go to IDLE when the tag FIFO is empty; no done_o is pulsed.
- start_i outside IDLE is ignored. abort_i in IDLE is ignored.
- abort_i while mem_req_o is high and mem_gnt_i is low: the request is dropped in the same cycle (allowed only because abort is a fabric-wide flush).

Eligibility and arbitration:
- Channel c is eligible when remaining[c] > 0 and occupancy[c] + inflight[c] < BUF_DEPTH.
- Round-robin search starts at ptr. The winner drives mem_addr_o = next_addr[c].
- mem_req_o is high when the tag FIFO is not full and any channel is eligible.
- While mem_req_o is high and mem_gnt_i is low, the selected channel and address are held stable.

On grant (mem_gnt_i high):
- Push c into the tag FIFO.
- next_addr[c] += stride, modulo 2^32 wrap.
- remaining[c] -= 1; inflight[c] += 1.
- ptr = c + 1 mod NUM_CH.

Request latency:
- mem_req_o rises in the cycle after start acceptance.
- Back-to-back grants are allowed, one per cycle.

Responses:
- On mem_rvalid_i, pop the tag, write mem_rdata_i into that channel's buffer and decrement inflight.
- Buffer space is guaranteed by the credit rule, so no overflow is possible.
- Simultaneous grant and rvalid in one cycle: both tag FIFO push and pop occur; counts stay consistent.

Streams:
- ch_valid_o[c] = buffer not empty. ch_data_o[c] = buffer head.
- Pop on valid & ready.
- Data reaches the stream at the earliest in the cycle after rvalid (registered buffer).

Other rules:
- A size-0 channel is never requested.
- All sizes 0: RUN goes to DONE immediately (done_o two cycles after start_i).
- Stride 0 re-reads the same address size times.

Test Plan:
1. Ch0 addr 0x80000000, size 80, stride 4; others size 0; gnt always high, rvalid one cycle later; ready high -> 80 requests at 0x80000000..0x8000013C; ch0 delivers 80 words in order; single done_o pulse.
2. All four channels size 3, stride 4, distinct bases -> grant order ch0,ch1,ch2,ch3 repeating; each stream gets its 3 words at the correct addresses.
3. Ch1 ready held low, size 10 -> at most BUF_DEPTH=2 reads outstanding/buffered for ch1; other channels continue; releasing ready completes ch1.
4. gnt low for 5 cycles during a request -> mem_addr_o and the selected channel are stable throughout; the address advances only after the gnt cycle.
5. Ch0 base 0xFFFFFFF8, stride 4, size 4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
6. abort_i with 3 reads outstanding -> no new requests; 3 responses dropped; ch_valid_o all 0; busy_o falls after the last rvalid; no done_o. A following start_i runs normally.
